// File: rtl/seq_det_pkg.sv
// Shared encodings and constants for the word-level "1010" detector controller.
package seq_det_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } ctrl_state_e;

  // Bit-serial detector states: how much of the pattern has been seen so far
  typedef enum logic [1:0] {
    DET_S0 = 2'd0,  // nothing
    DET_S1 = 2'd1,  // "1"
    DET_S2 = 2'd2,  // "10"
    DET_S3 = 2'd3   // "101"
  } det_state_e;

  // Target pattern, oldest bit in position 3
  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Word-in / result-out handshake bundle plus serial-side observation signals.
interface seq_det_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int TOT_W = 16
);
  logic             word_valid;
  logic [WIDTH-1:0] word_in;
  logic             word_ready;
  logic             flush;
  logic             ser_valid;
  logic             ser_bit;
  logic             det_pulse;
  logic             res_valid;
  logic [CNT_W-1:0] res_count;
  logic             res_ready;
  logic [TOT_W-1:0] total_count;

  // Producer/consumer side
  modport master (
    output word_valid, word_in, flush, res_ready,
    input  word_ready, ser_valid, ser_bit, det_pulse, res_valid, res_count, total_count
  );

  // Controller side
  modport slave (
    input  word_valid, word_in, flush, res_ready,
    output word_ready, ser_valid, ser_bit, det_pulse, res_valid, res_count, total_count
  );
endinterface

// File: rtl/mealy_1010.sv
// Bit-serial Mealy detector for overlapping occurrences of PATTERN.
module mealy_1010
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,   // synchronous, active-low
  input  logic en,    // advance on this bit
  input  logic clr,   // return to S0 (forget history)
  input  logic din,
  output logic dout
);

  det_state_e state_q, state_d;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state_q <= DET_S0;
    else      state_q <= state_d;
  end

  // Next-state: clear wins, otherwise advance only when enabled
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_S0;
    end else if (en) begin
      case (state_q)
        DET_S0:  state_d = (din == PATTERN[3]) ? DET_S1 : DET_S0;
        DET_S1:  state_d = (din == PATTERN[2]) ? DET_S2 : DET_S1;
        DET_S2:  state_d = (din == PATTERN[1]) ? DET_S3 : DET_S0;
        DET_S3:  state_d = (din == PATTERN[0]) ? DET_S2 : DET_S1; // match keeps "10" for overlap
        default: state_d = DET_S0;
      endcase
    end
  end

  // Mealy output: completing bit arrives while in S3
  always_comb begin
    dout = en && (state_q == DET_S3) && (din == PATTERN[0]);
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serializes words MSB-first into the detector, counts matches per word and in total.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int TOT_W = 16
) (
  input logic          clk,
  input logic          rst,   // synchronous, active-low
  seq_det_ctrl_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOT_W-1:0] total_q, total_d;

  logic ser_valid_w;
  logic ser_bit_w;
  logic det_clr_w;
  logic det_pulse_w;
  logic last_bit_w;

  assign last_bit_w = (idx_q == IDX_W'(WIDTH - 1));

  mealy_1010 u_det (
    .clk  (clk),
    .rst  (rst),
    .en   (ser_valid_w),
    .clr  (det_clr_w),
    .din  (ser_bit_w),
    .dout (det_pulse_w)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.word_valid) state_d = ST_SHIFT;
      ST_SHIFT:  if (last_bit_w)     state_d = ST_REPORT;
      ST_REPORT: if (bus.res_ready)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; ser_bit is forced low outside SHIFT so idle outputs are clean
  always_comb begin
    bus.word_ready  = (state_q == ST_IDLE);
    ser_valid_w     = (state_q == ST_SHIFT);
    ser_bit_w       = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
    det_clr_w       = (state_q == ST_IDLE) && bus.flush;
    bus.ser_valid   = ser_valid_w;
    bus.ser_bit     = ser_bit_w;
    bus.det_pulse   = det_pulse_w;
    bus.res_valid   = (state_q == ST_REPORT);
    bus.res_count   = cnt_q;
    bus.total_count = total_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

  // Datapath next-state: load on accept, shift and count while serializing
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    if ((state_q == ST_IDLE) && bus.word_valid) begin
      shreg_d = bus.word_in;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      idx_d   = idx_q + IDX_W'(1);
      if (det_pulse_w) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (total_q != {TOT_W{1'b1}}) total_d = total_q + TOT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a result scoreboard and a history-based reference.
module tb_seq_det_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_det_ctrl_if #(.WIDTH(8), .CNT_W(4), .TOT_W(16)) bus ();
  seq_det_ctrl_if #(.WIDTH(8), .CNT_W(4), .TOT_W(4))  bus4 ();

  // Narrow-total instance sees the same stimulus
  assign bus4.word_valid = bus.word_valid;
  assign bus4.word_in    = bus.word_in;
  assign bus4.flush      = bus.flush;
  assign bus4.res_ready  = bus.res_ready;

  seq_det_ctrl #(.WIDTH(8), .CNT_W(4), .TOT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  seq_det_ctrl #(.WIDTH(8), .CNT_W(4), .TOT_W(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  typedef struct {
    int cnt;
    int tot;
    int tot4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: last four presented bits since reset/flush
  logic [3:0] m_hist = 4'b0;
  int         m_hlen = 0;
  int         m_tot  = 0;
  int         m_tot4 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      $error("check %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_hist = 4'b0;
    m_hlen = 0;
    m_tot  = 0;
    m_tot4 = 0;
    sb.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_word_ready"}, 32'(bus.word_ready), 1);
    chk({tag, "_ser_valid"},  32'(bus.ser_valid), 0);
    chk({tag, "_ser_bit"},    32'(bus.ser_bit), 0);
    chk({tag, "_det_pulse"},  32'(bus.det_pulse), 0);
    chk({tag, "_res_valid"},  32'(bus.res_valid), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    chk_idle_outputs("reset");
    chk("reset_res_count", 32'(bus.res_count), 0);
    chk("reset_total",     32'(bus.total_count), 0);
    chk("reset_total4",    32'(bus4.total_count), 0);
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE
  task automatic do_word(input logic [7:0] w, input bit fl, input int hold, input bit hold_valid);
    logic [7:0] mask;
    int         cnt;
    int         n;
    exp_t       e;
    mask = '0;
    cnt  = 0;
    bus.word_valid = 1'b1;
    bus.word_in    = w;
    bus.flush      = fl;
    chk("word_ready_idle", 32'(bus.word_ready), 1);
    if (fl) m_hlen = 0;
    for (int i = 0; i < 8; i++) begin
      m_hist = {m_hist[2:0], w[7-i]};
      m_hlen++;
      if (m_hlen >= 4 && m_hist == 4'b1010) begin
        mask[i] = 1'b1;
        cnt++;
      end
    end
    m_tot  = (m_tot + cnt > 65535) ? 65535 : m_tot + cnt;
    m_tot4 = (m_tot4 + cnt > 15) ? 15 : m_tot4 + cnt;
    sb.push_back('{cnt: cnt, tot: m_tot, tot4: m_tot4});
    @(posedge clk); #1;
    bus.word_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.word_in    = '0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ser_valid_b%0d", i), 32'(bus.ser_valid), 1);
      chk($sformatf("ser_bit_b%0d", i),   32'(bus.ser_bit), 32'(w[7-i]));
      chk($sformatf("det_pulse_b%0d", i), 32'(bus.det_pulse), 32'(mask[i]));
      chk($sformatf("word_ready_b%0d", i), 32'(bus.word_ready), 0);
      @(posedge clk); #1;
    end
    chk("res_valid_at_T9", 32'(bus.res_valid), 1);
    n = 0;
    while (!bus.res_valid && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.res_valid) chk("res_valid_timeout", 32'(bus.res_valid), 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk("res_count",    32'(bus.res_count), 32'(e.cnt));
      chk("total_count",  32'(bus.total_count), 32'(e.tot));
      chk("res_count4",   32'(bus4.res_count), 32'(e.cnt));
      chk("total_count4", 32'(bus4.total_count), 32'(e.tot4));
      $display("word %b: count %0d total %0d total4 %0d", w, bus.res_count, bus.total_count, bus4.total_count);
      bus.word_valid = hold_valid;
      for (int d = 0; d < hold; d++) begin
        @(posedge clk); #1;
        chk("hold_res_valid",  32'(bus.res_valid), 1);
        chk("hold_res_count",  32'(bus.res_count), 32'(e.cnt));
        chk("hold_word_ready", 32'(bus.word_ready), 0);
        chk("hold_ser_valid",  32'(bus.ser_valid), 0);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("after_res_valid",  32'(bus.res_valid), 0);
    chk("after_word_ready", 32'(bus.word_ready), 1);
  endtask

  initial begin
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    bus.flush      = 1'b0;
    bus.res_ready  = 1'b0;

    // Basic word, then a match spanning the word boundary
    do_reset();
    do_word(8'b1010_1010, 1'b0, 0, 1'b0);
    do_word(8'b1000_0000, 1'b0, 0, 1'b0);

    // Same pair with a flush accepted together with the second word
    do_reset();
    do_word(8'b1010_1010, 1'b0, 0, 1'b0);
    do_word(8'b1000_0000, 1'b1, 0, 1'b0);

    // Flush pulsed alone in IDLE, then a word
    do_reset();
    do_word(8'b1010_1010, 1'b0, 0, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    m_hlen = 0;
    chk_idle_outputs("post_flush");
    do_word(8'b1000_0000, 1'b0, 0, 1'b0);

    // Consumer stall with word_valid held high; the held word goes next
    do_word(8'b0101_1010, 1'b0, 5, 1'b1);
    do_word(8'b1101_0011, 1'b0, 0, 1'b0);

    // Reset while bit 4 of a word is on the serial output
    bus.word_valid = 1'b1;
    bus.word_in    = 8'b1010_1010;
    @(posedge clk); #1;
    bus.word_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_at_bit4", 32'(bus.ser_valid), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    chk_idle_outputs("abort");
    chk("abort_res_count", 32'(bus.res_count), 0);
    chk("abort_total",     32'(bus.total_count), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (bus.res_valid || bus.ser_valid) seen++;
      end
      chk("abort_no_result", 32'(seen), 0);
    end

    // Saturation of the narrow total across five words
    do_reset();
    for (int k = 0; k < 5; k++) do_word(8'b1010_1010, 1'b0, 0, 1'b0);

    // A few random words to exercise other patterns
    for (int k = 0; k < 6; k++) do_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Word-level controller for the bit-serial Mealy "1010" sequence detector. Accepts parallel words over a valid/ready handshake and serializes them MSB-first into an embedded detector instance. Counts overlapping detections per word and returns each count over a second valid/ready handshake. Keeps a saturating running total, and sits between a word-oriented producer and the serial detection datapath.

## Interface
- WIDTH, 8, bits per input word
- CNT_W, 4, per-word count width (holds 0..WIDTH)
- TOT_W, 16, running-total width
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-low reset (rst=0 sampled at posedge resets the block)
- word_valid  in  1  producer has a word
- word_in  in  WIDTH  word, bit WIDTH-1 shifted first
- word_ready  out  1  block accepts a word this cycle
- flush  in  1  clear detector history (honoured only in IDLE)
- ser_valid  out  1  a bit is presented to the detector this cycle
- ser_bit  out  1  bit presented to the detector
- det_pulse  out  1  Mealy detector output, qualified by ser_valid
- res_valid  out  1  per-word result available
- res_count  out  CNT_W  detections within the reported word
- res_ready  in  1  consumer accepts the result
- total_count  out  TOT_W  saturating sum of all detections since reset

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - word_ready=1.
  - When word_valid=1, load the shift register with word_in, clear bit index and word count, and go to SHIFT.
- SHIFT:
  - ser_valid=1 and ser_bit = shift register MSB.
  - Shift left once per cycle.
  - On det_pulse=1, increment the word count and total_count.
  - After the WIDTH-th bit, go to REPORT.
- REPORT:
  - res_valid=1; res_count holds the final count, including any detection on the last bit.
  - Hold until res_ready=1, then go to IDLE.
- Detector states:
  - S0 (nothing): 1→S1, 0→S0.
  - S1 ("1"): 1→S1, 0→S2.
  - S2 ("10"): 1→S3, 0→S0.
  - S3 ("101"): 0→S2 with dout=1 (overlap), 1→S1.
  - Detector advances only when ser_valid=1.
- Detector state carries across words unless flushed. A match may span a word boundary and is counted in the later word.
- flush=1 in IDLE forces the detector to S0. If flush and word_valid are both 1 in the same cycle, the flush applies first and the word starts from S0. flush in SHIFT/REPORT is ignored.
- total_count saturates at 2^TOT_W-1 and is cleared only by reset. res_count cannot overflow (max WIDTH).

## Timing
- Handshakes:
  - A word transfers at a posedge with word_valid & word_ready.
  - A result transfers at a posedge with res_valid & res_ready.
- Word accepted at edge T:
  - bits presented in cycles T+1..T+WIDTH;
  - res_valid asserted from cycle T+WIDTH+1.
- Minimum word period: WIDTH+2 cycles (REPORT with res_ready=1, then one IDLE cycle).
- word_ready is 0 in SHIFT and REPORT; word_valid is ignored there.
- det_pulse is combinational (Mealy), in the same cycle as the completing ser_bit.
- Outputs after reset:
  - state IDLE and detector S0;
  - word_ready=1;
  - ser_valid, ser_bit, det_pulse, res_valid = 0;
  - res_count=0 and total_count=0.
- Reset mid-SHIFT or mid-REPORT discards the word and its result; no res_valid is produced.

## Structure
- Shared package seq_det_pkg holds:
  - FSM state encodings (IDLE/SHIFT/REPORT);
  - detector state encodings (S0..S3);
  - the target pattern constant 4'b1010.
- One sub-module, mealy_1010, with ports clk, rst, en, clr, din, dout. The controller instantiates it once; en=ser_valid, clr = flush in IDLE.
- The controller owns the FSM, shift register, bit index, counters and saturation logic.

## Test plan
- Reset, then word 8'b1010_1010 with res_ready=1 → det_pulse on bits 3, 5 and 7 (0-based presentation order), res_count=3, total_count=3, res_valid at T+9.
- Without flush, follow with 8'b1000_0000 → detector starts in S2, det_pulse on bit 1, res_count=1, total=4.
- Repeat that sequence with flush=1 pulsed in IDLE between the two words → second res_count=0, total=3.
- Hold res_ready=0 for 5 cycles in REPORT with word_valid=1 → res_valid and res_count stable, word_ready=0, no extra word accepted; the word is accepted in the IDLE cycle after res_ready.
- Drive rst=0 for one cycle at bit 4 of a word → next cycle IDLE, word_ready=1, all other outputs 0, no result for the aborted word.
- With TOT_W=4, stream five 8'b1010_1010 words without flush → res_count 3,4,4,4,4 and total_count 3,7,11,15,15 (saturated).
